// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolver: funct3 branch codes, FSM states and the PC step.
`timescale 1ns/1ps
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int PC_STEP = 4;

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESULT = 2'd1,
    FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/branch_condition.sv
// Combinational branch condition decode: funct3 plus comparator flags -> taken / illegal.
`timescale 1ns/1ps
module branch_condition
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       flag_equal,
  input  logic       flag_greater,
  input  logic       flag_greater_unsigned,
  output logic       taken,
  output logic       illegal
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = flag_equal;
      F3_BNE:  taken = !flag_equal;
      F3_BLT:  taken = !flag_greater && !flag_equal;
      F3_BGE:  taken = flag_greater || flag_equal;
      F3_BLTU: taken = !flag_greater_unsigned && !flag_equal;
      F3_BGEU: taken = flag_greater_unsigned || flag_equal;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Registered branch resolver with valid/ready handshake and post-mispredict flush.
// Define BRANCH_RESOLVER_STATS_EN to enable the saturating branch/mispredict counters.
`timescale 1ns/1ps
module branch_resolver
  import branch_pkg::*;
#(
  parameter int WORDSIZE     = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          funct3,
  input  logic [WORDSIZE-1:0] pc,
  input  logic [WORDSIZE-1:0] imm,
  input  logic                predicted_taken,
  input  logic                flag_equal,
  input  logic                flag_greater,
  input  logic                flag_greater_unsigned,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                taken,
  output logic [WORDSIZE-1:0] target,
  output logic [WORDSIZE-1:0] next_pc,
  output logic                mispredict,
  output logic                illegal,
  output logic                flush,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  localparam int CW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            accept, out_fire;
  logic            taken_c, illegal_c;
  logic [WORDSIZE-1:0] target_c, step_c;

  branch_condition u_cond (
    .funct3               (funct3),
    .flag_equal           (flag_equal),
    .flag_greater         (flag_greater),
    .flag_greater_unsigned(flag_greater_unsigned),
    .taken                (taken_c),
    .illegal              (illegal_c)
  );

  // Handshake signals derive only from registered state, never from out_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESULT);
  assign flush     = (state == FLUSH);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign target_c = pc + imm;
  assign step_c   = pc + WORDSIZE'(PC_STEP);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: if (in_valid) state_next = RESULT;
      RESULT: begin
        if (out_ready) begin
          if (mispredict && (FLUSH_CYCLES > 0)) begin
            state_next = FLUSH;
            cnt_next   = CW'(FLUSH_LOAD);
          end else begin
            state_next = IDLE;
          end
        end
      end
      FLUSH: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken      <= 1'b0;
      illegal    <= 1'b0;
      mispredict <= 1'b0;
      target     <= '0;
      next_pc    <= '0;
    end else if (accept) begin
      taken      <= taken_c;
      illegal    <= illegal_c;
      mispredict <= taken_c ^ predicted_taken;
      target     <= target_c;
      next_pc    <= taken_c ? target_c : step_c;
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (out_fire) begin
      if (branch_count != COUNT_MAX) branch_count <= branch_count + 32'd1;
      if (mispredict && (mispredict_count != COUNT_MAX))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule
